// File: rtl/k580_bus_pkg.sv
// Shared constants for the k580 bus controller and its interrupt controller:
// status-byte bit positions, the RST opcode template and register port offsets.
package k580_bus_pkg;

    localparam int ST_INTA = 0;
    localparam int ST_NWO  = 1;
    localparam int ST_STACK = 2;
    localparam int ST_HLTA = 3;
    localparam int ST_OUT  = 4;
    localparam int ST_M1   = 5;
    localparam int ST_INP  = 6;
    localparam int ST_MEMR = 7;

    localparam int PRIO_W = 3;

    // RST n is 11nnn111; OR the vector into bits 5:3 of this template.
    localparam logic [7:0] RST_OPCODE = 8'hC7;

    localparam logic [7:0] PORT_CMD_OFS  = 8'd0;
    localparam logic [7:0] PORT_MASK_OFS = 8'd1;

    function automatic logic [7:0] rst_opcode(input logic [PRIO_W-1:0] vec);
        return RST_OPCODE | {2'b00, vec, 3'b000};
    endfunction

endpackage

// File: rtl/k580_prio8.sv
// Eight-input priority encoder: returns the lowest set index (bit 0 wins)
// and a valid flag when any request is set.
module k580_prio8
    import k580_bus_pkg::*;
(
    input  logic [7:0]        req,
    output logic [PRIO_W-1:0] idx,
    output logic              valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scanning downward lets the lowest set bit overwrite higher ones.
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx   = PRIO_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/k580_busctl_pic.sv
// Bus-side responder for the k580wm80a core: status latch and strobe decode,
// plus an 8-input vectored interrupt controller answering INTA with RST n.
module k580_busctl_pic
    import k580_bus_pkg::*;
#(
    parameter logic [7:0] PORT_BASE = 8'hF0,
    parameter logic [7:0] EOI_CMD   = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        cpu_sync,
    input  logic [7:0]  cpu_odata,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_inta,
    input  logic [7:0]  ext_idata,
    input  logic [7:0]  irq,
    output logic [7:0]  cpu_idata,
    output logic        cpu_intr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        io_rd,
    output logic        io_wr,
    output logic        m1,
    output logic        stack,
    output logic        halt_ack,
    output logic [7:0]  status
);

    logic [7:0]        irr, isr, mask, irq_prev;
    logic [7:0]        irr_next, isr_next, pend, irq_rise;
    logic [PRIO_W-1:0] vec, cand, act;
    logic              vec_valid, inta_armed, cand_valid, act_valid;
    logic              port_cmd, port_mask, inta_sync, inta_ack, vec_rd;
    logic              eoi_hit, mask_hit;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr[15:8];

    assign mem_rd   = cpu_rd & status[ST_MEMR];
    assign io_rd    = cpu_rd & status[ST_INP];
    assign mem_wr   = cpu_wr & ~status[ST_OUT];
    assign io_wr    = cpu_wr & status[ST_OUT];
    assign m1       = status[ST_M1];
    assign stack    = status[ST_STACK];
    assign halt_ack = status[ST_HLTA];

    assign pend     = irr & ~mask;
    assign irq_rise = irq & ~irq_prev;

    k580_prio8 u_pend_prio (.req(pend), .idx(cand), .valid(cand_valid));
    k580_prio8 u_isr_prio  (.req(isr),  .idx(act),  .valid(act_valid));

    assign cpu_intr = cand_valid && (!act_valid || (cand < act));

    assign port_cmd  = (cpu_addr[7:0] == PORT_BASE + PORT_CMD_OFS);
    assign port_mask = (cpu_addr[7:0] == PORT_BASE + PORT_MASK_OFS);

    // INTA handshake: the M1 sync with INTA set freezes the vector and arms
    // the acknowledge; the first ce with cpu_inta high consumes it once.
    assign inta_sync = ce & cpu_sync & cpu_odata[ST_INTA] & cpu_odata[ST_M1];
    assign inta_ack  = ce & cpu_inta & inta_armed;
    assign vec_rd    = cpu_inta & status[ST_M1];

    assign eoi_hit  = ce & io_wr & port_cmd & (cpu_odata == EOI_CMD) & act_valid;
    assign mask_hit = ce & io_wr & port_mask;

    always_comb begin
        irr_next = irr;
        isr_next = isr;
        if (eoi_hit) begin
            isr_next[act] = 1'b0;
        end
        if (inta_ack && vec_valid) begin
            isr_next[vec] = 1'b1;
            irr_next[vec] = 1'b0;
        end
        // Applied last so a fresh edge on the acknowledged line survives.
        if (ce) begin
            irr_next = irr_next | irq_rise;
        end
    end

    always_comb begin
        cpu_idata = ext_idata;
        if (vec_rd) begin
            cpu_idata = rst_opcode(vec);
        end else if (io_rd && port_cmd) begin
            cpu_idata = irr;
        end else if (io_rd && port_mask) begin
            cpu_idata = mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status     <= 8'h00;
            irr        <= 8'h00;
            isr        <= 8'h00;
            irq_prev   <= 8'h00;
            mask       <= 8'hFF;
            vec        <= '0;
            vec_valid  <= 1'b0;
            inta_armed <= 1'b0;
        end else if (ce) begin
            irq_prev <= irq;
            irr      <= irr_next;
            isr      <= isr_next;
            if (cpu_sync) begin
                status <= cpu_odata;
            end
            if (mask_hit) begin
                mask <= cpu_odata;
            end
            if (inta_sync) begin
                // An empty request set answers RST 7 and acknowledges nothing.
                vec        <= cand_valid ? cand : PRIO_W'(7);
                vec_valid  <= cand_valid;
                inta_armed <= 1'b1;
            end else if (inta_ack) begin
                inta_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_k580_busctl_pic.sv
// Scenario bench for k580_busctl_pic: bus decode, register ports, interrupt
// priority/nesting, EOI, masking, empty INTA, halt and reset during INTA.
module tb_k580_busctl_pic;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        cpu_sync = 1'b0;
    logic [7:0]  cpu_odata = 8'h00;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_inta = 1'b0;
    logic [7:0]  ext_idata = 8'h00;
    logic [7:0]  irq = 8'h00;
    logic [7:0]  cpu_idata;
    logic        cpu_intr;
    logic        mem_rd, mem_wr, io_rd, io_wr;
    logic        m1, stack, halt_ack;
    logic [7:0]  status;

    localparam logic [15:0] P_CMD  = 16'h00F0;
    localparam logic [15:0] P_MASK = 16'h00F1;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    k580_busctl_pic #(.PORT_BASE(8'hF0), .EOI_CMD(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_sync(cpu_sync),
        .cpu_odata(cpu_odata), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_inta(cpu_inta), .ext_idata(ext_idata),
        .irq(irq), .cpu_idata(cpu_idata), .cpu_intr(cpu_intr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .io_rd(io_rd), .io_wr(io_wr),
        .m1(m1), .stack(stack), .halt_ack(halt_ack), .status(status)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic sync_status(input logic [7:0] st);
        @(negedge clk);
        cpu_sync  = 1'b1;
        cpu_odata = st;
        @(negedge clk);
        cpu_sync  = 1'b0;
        cpu_odata = 8'h00;
        #2;
    endtask

    task automatic read_begin(input logic [15:0] a, input logic inta);
        @(negedge clk);
        cpu_addr  = a;
        cpu_inta  = inta;
        cpu_rd    = ~inta;
        ext_idata = 8'($urandom_range(0, 255));
        #2;
    endtask

    task automatic read_end();
        @(negedge clk);
        cpu_rd   = 1'b0;
        cpu_inta = 1'b0;
        #2;
    endtask

    task automatic write_begin(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr  = a;
        cpu_odata = d;
        cpu_wr    = 1'b1;
        #2;
    endtask

    task automatic write_end();
        @(negedge clk);
        cpu_wr    = 1'b0;
        cpu_odata = 8'h00;
        #2;
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d);
        sync_status(8'h10);
        write_begin(a, d);
        write_end();
    endtask

    task automatic io_in_begin(input logic [15:0] a);
        sync_status(8'h42);
        read_begin(a, 1'b0);
    endtask

    task automatic inta_begin();
        sync_status(8'hA3);
        read_begin(16'h0000, 1'b1);
    endtask

    task automatic irq_edge(input int b);
        @(negedge clk);
        irq[b] = 1'b1;
        @(negedge clk);
        irq[b] = 1'b0;
        #2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        ext_idata = 8'h3C;
        #2;
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL rst_intr got=%b exp=0", cpu_intr); end
        checks++; if ({mem_rd, mem_wr, io_rd, io_wr} !== 4'b0000) begin errors++; $display("FAIL rst_strobes got=%b exp=0000", {mem_rd, mem_wr, io_rd, io_wr}); end
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL rst_status got=%h exp=00", status); end
        checks++; if (cpu_idata !== 8'h3C) begin errors++; $display("FAIL rst_idata got=%h exp=3c", cpu_idata); end
        reset_n = 1'b1;
        io_in_begin(P_MASK);
        exp_q.push_back(8'hFF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL rst_mask got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_in_begin(P_CMD);
        exp_q.push_back(8'h00);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL rst_irr got=%h exp=%h", cpu_idata, exp); end
        read_end();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            sync_status(8'hA2);
            read_begin(16'($urandom_range(0, 65535)), 1'b0);
            exp_q.push_back(ext_idata);
            checks++; if ({m1, mem_rd, io_rd, stack} !== 4'b1100) begin errors++; $display("FAIL fetch_decode got=%b exp=1100", {m1, mem_rd, io_rd, stack}); end
            checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL fetch_data got=%h exp=%h", cpu_idata, exp); end
            read_end();
        end
    endtask

    task automatic test_io();
        sync_status(8'h10);
        write_begin(16'h0010, 8'h5A);
        checks++; if ({io_wr, mem_wr} !== 2'b10) begin errors++; $display("FAIL out_strobes got=%b exp=10", {io_wr, mem_wr}); end
        write_end();
        sync_status(8'h04);
        write_begin(16'h8000, 8'h11);
        checks++; if ({io_wr, mem_wr, stack} !== 3'b011) begin errors++; $display("FAIL stack_wr got=%b exp=011", {io_wr, mem_wr, stack}); end
        write_end();
        io_out(P_MASK, 8'h00);
        io_in_begin(P_MASK);
        exp_q.push_back(8'h00);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL mask_rd got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_in_begin(16'h0022);
        exp_q.push_back(ext_idata);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL other_port got=%h exp=%h", cpu_idata, exp); end
        read_end();
    endtask

    task automatic test_irq();
        @(negedge clk);
        irq[3] = 1'b1;
        #2;
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL intr_early got=%b exp=0", cpu_intr); end
        @(negedge clk);
        irq[3] = 1'b0;
        #2;
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL intr_irq3 got=%b exp=1", cpu_intr); end
        io_in_begin(P_CMD);
        exp_q.push_back(8'h08);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL irr_irq3 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        inta_begin();
        exp_q.push_back(8'hDF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq3 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL intr_after_ack got=%b exp=0", cpu_intr); end
        io_in_begin(P_CMD);
        exp_q.push_back(8'h00);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL irr_after_ack got=%h exp=%h", cpu_idata, exp); end
        read_end();
    endtask

    task automatic test_nesting();
        irq_edge(5);
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL nest_low_blocked got=%b exp=0", cpu_intr); end
        irq_edge(1);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL nest_high_intr got=%b exp=1", cpu_intr); end
        inta_begin();
        exp_q.push_back(8'hCF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq1 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_out(P_CMD, 8'h20);
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL eoi1_intr got=%b exp=0", cpu_intr); end
        io_out(P_CMD, 8'h21);
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL non_eoi_data got=%b exp=0", cpu_intr); end
        io_out(P_CMD, 8'h20);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL eoi2_intr got=%b exp=1", cpu_intr); end
        inta_begin();
        exp_q.push_back(8'hEF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq5 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_out(P_CMD, 8'h20);
    endtask

    task automatic test_mask();
        io_out(P_MASK, 8'h04);
        irq_edge(2);
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL masked_intr got=%b exp=0", cpu_intr); end
        io_in_begin(P_CMD);
        exp_q.push_back(8'h04);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL masked_irr got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_out(P_MASK, 8'h00);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL unmask_intr got=%b exp=1", cpu_intr); end
        inta_begin();
        exp_q.push_back(8'hD7);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq2 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_out(P_CMD, 8'h20);
    endtask

    task automatic test_empty_inta();
        inta_begin();
        exp_q.push_back(8'hFF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_empty got=%h exp=%h", cpu_idata, exp); end
        read_end();
        irq_edge(7);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL empty_isr_clean got=%b exp=1", cpu_intr); end
        inta_begin();
        exp_q.push_back(8'hFF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq7 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL irq7_acked got=%b exp=0", cpu_intr); end
        io_out(P_CMD, 8'h20);
    endtask

    task automatic test_back_to_back();
        irq_edge(4);
        sync_status(8'hA3);
        @(negedge clk);
        cpu_inta = 1'b1;
        irq[4]   = 1'b1;
        #2;
        exp_q.push_back(8'hE7);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL vec_irq4 got=%h exp=%h", cpu_idata, exp); end
        read_end();
        irq[4] = 1'b0;
        io_in_begin(P_CMD);
        exp_q.push_back(8'h10);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL set_wins_irr got=%h exp=%h", cpu_idata, exp); end
        read_end();
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL same_level_blocked got=%b exp=0", cpu_intr); end
        io_out(P_CMD, 8'h20);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL reraise_intr got=%b exp=1", cpu_intr); end
        inta_begin();
        read_end();
        io_out(P_CMD, 8'h20);
    endtask

    task automatic test_halt_reset();
        sync_status(8'h8A);
        sync_status(8'h8A);
        checks++; if ({halt_ack, m1} !== 2'b10) begin errors++; $display("FAIL halt_ack got=%b exp=10", {halt_ack, m1}); end
        ce = 1'b0;
        sync_status(8'hA2);
        checks++; if (status !== 8'h8A) begin errors++; $display("FAIL ce_hold got=%h exp=8a", status); end
        ce = 1'b1;
        irq_edge(6);
        checks++; if (cpu_intr !== 1'b1) begin errors++; $display("FAIL pre_rst_intr got=%b exp=1", cpu_intr); end
        sync_status(8'hA3);
        @(negedge clk);
        cpu_inta = 1'b1;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        cpu_inta = 1'b0;
        #2;
        checks++; if ({cpu_intr, halt_ack} !== 2'b00) begin errors++; $display("FAIL post_rst got=%b exp=00", {cpu_intr, halt_ack}); end
        io_in_begin(P_MASK);
        exp_q.push_back(8'hFF);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL post_rst_mask got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_in_begin(P_CMD);
        exp_q.push_back(8'h00);
        checks++; exp = exp_q.pop_front(); if (cpu_idata !== exp) begin errors++; $display("FAIL post_rst_irr got=%h exp=%h", cpu_idata, exp); end
        read_end();
        io_out(P_MASK, 8'h00);
        checks++; if (cpu_intr !== 1'b0) begin errors++; $display("FAIL post_rst_isr_clean got=%b exp=0", cpu_intr); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fetch();
        test_io();
        test_irq();
        test_nesting();
        test_mask();
        test_empty_inta();
        test_back_to_back();
        test_halt_reset();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
